// File: rtl/alu_logic_responder_if.sv
// Request/response bundle for the ALU logic responder: an operand request channel
// and a result response channel, each with its own valid/ready handshake.
interface alu_logic_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  // Initiator/consumer side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  // Responder side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_logic_responder.sv
// Bitwise-logic responder: computes AND/OR/XOR/NAND/NOR/XNOR/ANDN on an accepted
// request and returns the result through a 2-entry FIFO response buffer.
module alu_logic_responder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_logic_responder_if.slave bus,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } entry_t;

  state_t state, next_state;
  entry_t head, tail, new_entry;
  logic   rdy, vld, accept, pop;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (bus.req_op)
      3'b000:  res_data = bus.req_a & bus.req_b;
      3'b001:  res_data = bus.req_a | bus.req_b;
      3'b010:  res_data = bus.req_a ^ bus.req_b;
      3'b011:  res_data = ~(bus.req_a & bus.req_b);
      3'b100:  res_data = ~(bus.req_a | bus.req_b);
      3'b101:  res_data = ~(bus.req_a ^ bus.req_b);
      3'b110:  res_data = bus.req_a & ~bus.req_b;
      default: res_err  = 1'b1;
    endcase
    new_entry = '{data: res_data, zero: (res_data == '0), err: res_err};
  end

  // Handshake strobes depend only on the registered state, so req_ready never
  // combinationally follows rsp_ready.
  always_comb begin
    next_state = state;
    rdy        = 1'b0;
    vld        = 1'b0;
    accept     = 1'b0;
    pop        = 1'b0;
    unique case (state)
      EMPTY: begin
        rdy    = 1'b1;
        accept = bus.req_valid;
        if (accept) next_state = ONE;
      end
      ONE: begin
        rdy    = 1'b1;
        vld    = 1'b1;
        accept = bus.req_valid;
        pop    = bus.rsp_ready;
        if (accept && !pop)      next_state = FULL;
        else if (!accept && pop) next_state = EMPTY;
      end
      FULL: begin
        vld = 1'b1;
        pop = bus.rsp_ready;
        if (pop) next_state = ONE;
      end
      default: next_state = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // Head always holds the oldest entry; tail only holds the second one in FULL.
  // NOTE: both buffer slots are cleared on reset so discarded entries can never
  // resurface on rsp_data after a mid-operation reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      op_count <= '0;
    end else begin
      if (accept) op_count <= op_count + CNT_W'(1);
      unique case (state)
        EMPTY: if (accept) head <= new_entry;
        ONE: begin
          if (accept && pop) head <= new_entry;
          else if (accept)   tail <= new_entry;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = vld;
  assign bus.rsp_data  = vld ? head.data : '0;
  assign bus.rsp_zero  = vld & head.zero;
  assign bus.rsp_err   = vld & head.err;

endmodule

// File: tb/tb_alu_logic_responder.sv
// Scoreboard bench for alu_logic_responder: the driver queues the expected entry
// on each accept, the negedge monitor compares the head and pops on each response.
module tb_alu_logic_responder;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] cnt_model = '0;
  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  alu_logic_responder_if #(.WIDTH(WIDTH)) bus ();

  alu_logic_responder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic z, input logic e);
    exp_t r;
    r.data = d;
    r.zero = z;
    r.err  = e;
    return r;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = 32'h0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a | b;
      3'd2: d = a ^ b;
      3'd3: d = ~(a & b);
      3'd4: d = ~(a | b);
      3'd5: d = ~(a ^ b);
      3'd6: d = a & ~b;
      default: return mk(32'h0, 1'b1, 1'b1);
    endcase
    return mk(d, d == 32'h0, 1'b0);
  endfunction

  // Checks the head entry every cycle and retires it on a pop.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      cnt_model = '0;
    end else begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(sb.size() != 0));
      check("req_ready", 32'(bus.req_ready), 32'(sb.size() < 2));
      if (sb.size() != 0) begin
        check("rsp_data", bus.rsp_data, sb[0].data);
        check("rsp_zero", 32'(bus.rsp_zero), 32'(sb[0].zero));
        check("rsp_err",  32'(bus.rsp_err),  32'(sb[0].err));
      end else begin
        check("idle_data", bus.rsp_data, 32'h0);
        check("idle_flags", 32'({bus.rsp_zero, bus.rsp_err}), 32'h0);
      end
      check("op_count", 32'(op_count), 32'(cnt_model));
      if (bus.req_valid && bus.req_ready) cnt_model++;
      if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) void'(sb.pop_front());
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1 check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] sweep_exp [7];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    sweep_exp = '{32'h8888_8888, 32'hEEEE_EEEE, 32'h6666_6666, 32'h7777_7777,
                  32'h1111_1111, 32'h9999_9999, 32'h2222_2222};

    // Reset and idle
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);

    // Directed basic op
    bus.rsp_ready = 1'b1;
    send(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, mk(32'h00F0_1234, 1'b0, 1'b0));
    check("basic_valid", 32'(bus.rsp_valid), 32'd1);
    check("basic_data", bus.rsp_data, 32'h00F0_1234);
    check("basic_count", 32'(op_count), 32'd1);
    drain();

    // Opcode sweep back to back, then zero result and illegal opcode
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++)
      send(3'(i), 32'hAAAA_AAAA, 32'hCCCC_CCCC, mk(sweep_exp[i], 1'b0, 1'b0));
    drain();
    check("sweep_count", 32'(op_count), 32'd7);
    send(3'b000, 32'd5, 32'd10, mk(32'h0, 1'b1, 1'b0));
    send(3'b111, 32'hFFFF_FFFF, 32'h1234_5678, mk(32'h0, 1'b1, 1'b1));
    drain();
    check("illegal_count", 32'(op_count), 32'd9);

    // Back-pressure: fill, hold R3 off, then release
    do_reset();
    bus.rsp_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, mk(32'd1, 1'b0, 1'b0));
    send(3'b001, 32'd2, 32'd3, mk(32'd3, 1'b0, 1'b0));
    check("full_req_ready", 32'(bus.req_ready), 32'd0);
    fork
      send(3'b000, 32'd3, 32'd3, mk(32'd3, 1'b0, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1 check("r3_held_count", 32'(op_count), 32'd2);
        bus.rsp_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(op_count), 32'd3);

    // Random ops with random back-pressure
    fork
      for (int i = 0; i < 20; i++) begin
        logic [2:0]  op;
        logic [31:0] a, b;
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = $urandom;
        send(op, a, b, model(op, a, b));
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Counter wrap, then reset while FULL
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send(3'b000, 32'(i), 32'hFFFF_FFFF, mk(32'(i), i == 0, 1'b0));
    drain();
    check("wrap_count", 32'(op_count), 32'd1);
    bus.rsp_ready = 1'b0;
    send(3'b010, 32'hDEAD_BEEF, 32'd0, mk(32'hDEAD_BEEF, 1'b0, 1'b0));
    send(3'b001, 32'hCAFE_0000, 32'd0, mk(32'hCAFE_0000, 1'b0, 1'b0));
    check("pre_rst_full", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_count", 32'(op_count), 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("stale_never_seen", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end
endmodule
